// File: rtl/gpio_bank_ctrl.sv
// Configurable GPIO bank: per-pin pad mode, input synchroniser/debouncer,
// edge detection and sticky maskable interrupts.
module gpio_bank_ctrl #(
  parameter int N_IO        = 12,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_LIMIT   = 3,
  parameter int DEB_W       = 4,
  localparam int AW         = (N_IO > 1) ? $clog2(N_IO) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [2:0]      cfg_mode,
  input  logic [N_IO-1:0] out_data,
  input  logic [N_IO-1:0] out_en,
  input  logic [N_IO-1:0] irq_en,
  input  logic [N_IO-1:0] irq_clr,
  input  logic [N_IO-1:0] io_in,
  output logic [N_IO-1:0] io_out,
  output logic [N_IO-1:0] io_oeb,
  output logic [N_IO-1:0] in_data,
  output logic [N_IO-1:0] rise_pulse,
  output logic [N_IO-1:0] fall_pulse,
  output logic [N_IO-1:0] irq_pend,
  output logic            irq
);

  typedef enum logic [2:0] {
    MODE_INPUT  = 3'd0,
    MODE_OUTPUT = 3'd1,
    MODE_BIDIR  = 3'd2,
    MODE_FORCE0 = 3'd3,
    MODE_FORCE1 = 3'd4
  } mode_e;

  logic [2:0]      mode_q [N_IO];
  logic [N_IO-1:0] sync_q [SYNC_STAGES];
  logic [N_IO-1:0] sync_s;
  logic [N_IO-1:0] in_nxt;

  // Codes 5..7 are stored verbatim; out-of-range addresses match no pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_IO; i++) mode_q[i] <= MODE_INPUT;
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < N_IO; i++) begin
        if (cfg_addr == AW'(i)) mode_q[i] <= cfg_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_oeb <= '1;
      io_out <= '0;
    end else begin
      for (int unsigned i = 0; i < N_IO; i++) begin
        case (mode_e'(mode_q[i]))
          MODE_OUTPUT: begin io_oeb[i] <= 1'b0;       io_out[i] <= out_data[i]; end
          MODE_BIDIR:  begin io_oeb[i] <= ~out_en[i]; io_out[i] <= out_data[i]; end
          MODE_FORCE0: begin io_oeb[i] <= 1'b0;       io_out[i] <= 1'b0;        end
          MODE_FORCE1: begin io_oeb[i] <= 1'b0;       io_out[i] <= 1'b1;        end
          default:     begin io_oeb[i] <= 1'b1;       io_out[i] <= 1'b0;        end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  generate
    if (DEB_LIMIT <= 1) begin : g_nodeb
      assign in_nxt = sync_s;
    end else begin : g_deb
      localparam logic [DEB_W-1:0] LIM = DEB_W'(DEB_LIMIT - 1);
      logic [DEB_W-1:0] cnt_q [N_IO];
      logic [N_IO-1:0]  accept;

      // accept: mismatch has persisted for DEB_LIMIT cycles including this one
      always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < N_IO; i++) begin
          accept[i] = (sync_s[i] != in_data[i]) && (cnt_q[i] == LIM);
        end
      end

      assign in_nxt = in_data ^ accept;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < N_IO; i++) cnt_q[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < N_IO; i++) begin
            if ((sync_s[i] == in_data[i]) || accept[i]) cnt_q[i] <= '0;
            else                                         cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Pulses and pending bits share the edge at which in_data takes its new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_data    <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      irq_pend   <= '0;
    end else begin
      in_data    <= in_nxt;
      rise_pulse <= in_nxt & ~in_data;
      fall_pulse <= ~in_nxt & in_data;
      irq_pend   <= (irq_pend & ~irq_clr) | ((in_nxt ^ in_data) & irq_en);
    end
  end

  assign irq = |irq_pend;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Scoreboard bench for gpio_bank_ctrl: a behavioural model queues the expected
// pad/input/interrupt state each clock, a monitor compares on the falling edge.
module tb_gpio_bank_ctrl;
  localparam int N  = 12;
  localparam int SS = 2;
  localparam int DL = 3;
  localparam int L  = (DL > 1) ? DL : 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [2:0]   cfg_mode;
  logic [N-1:0] out_data, out_en, irq_en, irq_clr, io_in;
  logic [N-1:0] io_out, io_oeb, in_data, rise_pulse, fall_pulse, irq_pend;
  logic         irq;

  logic       cfg_we_b;
  logic [0:0] cfg_addr_b;
  logic [2:0] cfg_mode_b;
  logic [0:0] out_data_b, out_en_b, irq_en_b, irq_clr_b, io_in_b;
  logic [0:0] io_out_b, io_oeb_b, in_data_b, rise_b, fall_b, pend_b;
  logic       irq_b;

  gpio_bank_ctrl #(.N_IO(N), .SYNC_STAGES(SS), .DEB_LIMIT(DL), .DEB_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .out_data(out_data), .out_en(out_en), .irq_en(irq_en), .irq_clr(irq_clr), .io_in(io_in),
    .io_out(io_out), .io_oeb(io_oeb), .in_data(in_data), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .irq_pend(irq_pend), .irq(irq)
  );

  gpio_bank_ctrl #(.N_IO(1), .SYNC_STAGES(3), .DEB_LIMIT(0), .DEB_W(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b), .cfg_mode(cfg_mode_b),
    .out_data(out_data_b), .out_en(out_en_b), .irq_en(irq_en_b), .irq_clr(irq_clr_b), .io_in(io_in_b),
    .io_out(io_out_b), .io_oeb(io_oeb_b), .in_data(in_data_b), .rise_pulse(rise_b),
    .fall_pulse(fall_b), .irq_pend(pend_b), .irq(irq_b)
  );

  typedef struct packed {
    logic [N-1:0] oeb, out, ind, rise, fall, pend;
    logic         irq;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state
  int unsigned  m_mode [N];
  logic [N-1:0] m_lvl, m_pend;
  logic [N-1:0] io_pipe[$];
  logic [N-1:0] s_hist[$];

  function automatic exp_t rst_item();
    exp_t e;
    e = '0;
    e.oeb = '1;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mode[i] = 0;
    m_lvl  = '0;
    m_pend = '0;
    io_pipe.delete();
    s_hist.delete();
    repeat (SS) io_pipe.push_back('0);
    repeat (L)  s_hist.push_back('0);
  endtask

  always @(posedge clk) begin
    exp_t         e;
    logic [N-1:0] s_now, nl;
    bit           all_diff;
    if (!rst_n) begin
      model_reset();
      sb.push_back(rst_item());
    end else begin
      e = '0;
      for (int i = 0; i < N; i++) begin
        case (m_mode[i])
          1:       begin e.oeb[i] = 1'b0;       e.out[i] = out_data[i]; end
          2:       begin e.oeb[i] = ~out_en[i]; e.out[i] = out_data[i]; end
          3:       begin e.oeb[i] = 1'b0;       e.out[i] = 1'b0;        end
          4:       begin e.oeb[i] = 1'b0;       e.out[i] = 1'b1;        end
          default: begin e.oeb[i] = 1'b1;       e.out[i] = 1'b0;        end
        endcase
      end
      if (cfg_we && int'(cfg_addr) < N) m_mode[cfg_addr] = cfg_mode;
      s_now = io_pipe[SS-1];
      io_pipe.push_front(io_in);
      void'(io_pipe.pop_back());
      s_hist.push_front(s_now);
      if (s_hist.size() > L) void'(s_hist.pop_back());
      // a pin flips once its last L synchronised samples all disagree with it
      nl = m_lvl;
      for (int i = 0; i < N; i++) begin
        all_diff = 1'b1;
        foreach (s_hist[j]) if (s_hist[j][i] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) nl[i] = ~m_lvl[i];
      end
      e.rise = nl & ~m_lvl;
      e.fall = ~nl & m_lvl;
      m_pend = (m_pend & ~irq_clr) | ((nl ^ m_lvl) & irq_en);
      m_lvl  = nl;
      e.ind  = nl;
      e.pend = m_pend;
      e.irq  = |m_pend;
      sb.push_back(e);
    end
  end

  // Asynchronous reset overrides whatever was expected for the current cycle.
  always @(negedge rst_n) begin
    model_reset();
    if (sb.size() != 0) sb[sb.size()-1] = rst_item();
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("io_oeb",     io_oeb,     e.oeb);
      check("io_out",     io_out,     e.out);
      check("in_data",    in_data,    e.ind);
      check("rise_pulse", rise_pulse, e.rise);
      check("fall_pulse", fall_pulse, e.fall);
      check("irq_pend",   irq_pend,   e.pend);
      check("irq",        irq,        e.irq);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [2:0] m);
    cfg_we = 1'b1; cfg_addr = a; cfg_mode = m;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_in(input logic [N-1:0] mask, input logic [N-1:0] val,
                         input int exp_n, input string name);
    int n = 0;
    while (((in_data & mask) !== (val & mask)) && n < 20) begin
      step();
      n++;
    end
    check(name, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0;
    out_data = '1; out_en = '0; irq_en = '0; irq_clr = '0; io_in = '1;
    cfg_we_b = 1'b0; cfg_addr_b = '0; cfg_mode_b = '0;
    out_data_b = '0; out_en_b = '0; irq_en_b = '0; irq_clr_b = '0; io_in_b = '0;
    step(3);
    check("rst_oeb", io_oeb, 12'hFFF);
    check("rst_out", io_out, 12'h000);
    check("rst_in",  in_data, 12'h000);
    check("rst_irq", irq, 1'b0);

    rst_n = 1'b1;
    wait_in('1, '1, 5, "release_latency");
    check("release_rise", rise_pulse, 12'hFFF);
    step();
    check("release_rise_end", rise_pulse, 12'h000);

    out_data = '0; out_en = 12'h040;
    cfg_write(3, 1); cfg_write(4, 4); cfg_write(5, 3); cfg_write(6, 2); cfg_write(7, 6);
    step();
    check("mode_oeb", io_oeb[7:3], 5'b10000);
    check("mode_out", io_out[7:3], 5'b00010);
    out_en = '0;
    step();
    check("bidir_oeb", io_oeb[6], 1'b1);
    cfg_write(13, 4);
    step();
    check("badaddr_oeb", io_oeb, 12'hFC7);
    check("badaddr_out", io_out, 12'h010);

    io_in[0] = 1'b0;
    wait_in(12'h001, 12'h000, 5, "pin0_fall_latency");
    step(3);
    io_in[0] = 1'b1; step(2); io_in[0] = 1'b0;
    step(8);
    check("glitch_held", in_data[0], 1'b0);
    io_in[0] = 1'b1;
    wait_in(12'h001, 12'h001, 5, "pin0_rise_latency");
    check("pin0_rise", rise_pulse[0], 1'b1);
    step(3);

    io_in[2:1] = 2'b00;
    step(8);
    irq_en = 12'h004;
    io_in[2:1] = 2'b11;
    step(8);
    check("irq_pend_sel", irq_pend, 12'h004);
    check("irq_set", irq, 1'b1);
    irq_clr = 12'h004; step(); irq_clr = '0;
    check("irq_clr", irq, 1'b0);
    io_in[2] = 1'b0;
    step(4);
    irq_clr = 12'h004; step(); irq_clr = '0;
    check("set_wins_fall", fall_pulse[2], 1'b1);
    check("set_wins_pend", irq_pend[2], 1'b1);
    step(2);

    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) io_in[b] = ~io_in[b];
      out_data = N'($urandom);
      out_en   = N'($urandom);
      irq_en   = N'($urandom);
      irq_clr  = ($urandom_range(7) == 0) ? N'($urandom) : '0;
      cfg_we   = ($urandom_range(3) == 0);
      cfg_addr = 4'($urandom_range(15));
      cfg_mode = 3'($urandom_range(7));
      step();
    end
    cfg_we = 1'b0;

    io_in = '0; irq_en = '0; irq_clr = '1;
    step(10);
    irq_clr = '0;
    cfg_write(8, 4);
    irq_en = 12'h004;
    io_in[2] = 1'b1;
    step(6);
    check("pre_rst_oeb8", io_oeb[8], 1'b0);
    check("pre_rst_pend", irq_pend, 12'h004);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_oeb8", io_oeb[8], 1'b1);
    check("midrst_pend", irq_pend, 12'h000);
    check("midrst_irq", irq, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);

    io_in_b = 1'b1;
    n = 0;
    while (in_data_b !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("sweep_latency", n, 4);
    cfg_we_b = 1'b1; cfg_addr_b = 1'b0; cfg_mode_b = 3'd1;
    step();
    cfg_we_b = 1'b0;
    out_data_b = 1'b1;
    step();
    check("sweep_out1", io_out_b, 1'b1);
    check("sweep_oeb", io_oeb_b, 1'b0);
    out_data_b = 1'b0;
    step();
    check("sweep_out0", io_out_b, 1'b0);
    cfg_we_b = 1'b1; cfg_addr_b = 1'b1; cfg_mode_b = 3'd0;
    step();
    cfg_we_b = 1'b0;
    step();
    check("sweep_badaddr", io_oeb_b, 1'b0);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
